// File: rtl/alu_seq_param_if.sv
// alu_seq_param_if: operand/request and result/flag bundle
// master drives requests, slave (the ALU) returns results
interface alu_seq_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic [1:0]         operation;
  logic               start;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               done;
  logic               overflow;
  logic               zero;
  logic               div_by_zero;

  modport master (
    output operand_a, operand_b, operation, start,
    input  result, ready, done, overflow, zero, div_by_zero
  );

  modport slave (
    input  operand_a, operand_b, operation, start,
    output result, ready, done, overflow, zero, div_by_zero
  );
endinterface

// File: rtl/alu_seq_param.sv
// alu_seq_param: sequential signed ALU
// single-cycle add/sub, Booth radix-4 mul, non-restoring div
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  alu_seq_param_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc, mcand;
  logic [WIDTH-1:0] mplier;
  logic             prev;
  logic [WIDTH+1:0] rem;
  logic [WIDTH-1:0] quo, dvs;
  logic             neg_a, neg_b, div_ovf;

  logic [W2-1:0] result_q;
  logic          done_q, ovf_q, zero_q, dbz_q;

  logic [WIDTH-1:0] a, b;
  assign a = bus.operand_a;
  assign b = bus.operand_b;

  assign bus.result      = result_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.ready       = (state == IDLE);

  // add/sub with one guard bit to expose signed overflow
  logic [WIDTH:0]   as_ext;
  logic [WIDTH-1:0] as_lo;
  always_comb begin
    if (bus.operation[0])
      as_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    else
      as_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  end
  assign as_lo = as_ext[WIDTH-1:0];

  // Booth radix-4 partial product from the current recoding window
  logic [2:0]    bsel;
  logic [W2-1:0] pp, acc_nxt;
  assign bsel = {mplier[1:0], prev};
  always_comb begin
    pp = '0;
    case (bsel)
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end
  assign acc_nxt = acc + pp;

  logic mul_ovf;
  assign mul_ovf = ~((&acc_nxt[W2-1:WIDTH-1]) |
                     ~(|acc_nxt[W2-1:WIDTH-1]));

  // non-restoring step on magnitudes; quo doubles as dividend shifter
  logic [WIDTH+1:0] rem_sh, rem_nxt;
  assign rem_sh  = {rem[WIDTH:0], quo[WIDTH-1]};
  assign rem_nxt = rem[WIDTH+1] ? rem_sh + {2'b00, dvs}
                                : rem_sh - {2'b00, dvs};

  logic [WIDTH-1:0] rem_fix, rem_s, quo_s, abs_a, abs_b;
  assign rem_fix = rem[WIDTH-1:0] + (rem[WIDTH+1] ? dvs : '0);
  assign rem_s   = neg_a ? -rem_fix : rem_fix;
  assign quo_s   = (neg_a ^ neg_b) ? -quo : quo;
  assign abs_a   = a[WIDTH-1] ? -a : a;
  assign abs_b   = b[WIDTH-1] ? -b : b;

  logic div_min_neg1;
  assign div_min_neg1 = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.operation == 2'b10)
            state_nxt = MUL;
          else if (bus.operation == 2'b11 && b != '0)
            state_nxt = DIV;
        end
      end
      MUL:     if (cnt == MUL_LAST) state_nxt = IDLE;
      DIV:     if (cnt == DIV_LAST) state_nxt = DIV_FIX;
      DIV_FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath, result and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prev     <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_ovf  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt <= '0;
            if (!bus.operation[1]) begin
              result_q <= {{WIDTH{as_lo[WIDTH-1]}}, as_lo};
              ovf_q    <= as_ext[WIDTH] ^ as_ext[WIDTH-1];
              zero_q   <= (as_lo == '0);
              dbz_q    <= 1'b0;
              done_q   <= 1'b1;
            end else if (!bus.operation[0]) begin
              acc    <= '0;
              mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
              mplier <= b;
              prev   <= 1'b0;
            end else if (b == '0) begin
              result_q <= {a, {WIDTH{1'b1}}};
              ovf_q    <= 1'b1;
              zero_q   <= 1'b0;
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              rem     <= '0;
              quo     <= abs_a;
              dvs     <= abs_b;
              neg_a   <= a[WIDTH-1];
              neg_b   <= b[WIDTH-1];
              div_ovf <= div_min_neg1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 2;
          mplier <= {2'b00, mplier[WIDTH-1:2]};
          prev   <= mplier[1];
          cnt    <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            result_q <= acc_nxt;
            ovf_q    <= mul_ovf;
            zero_q   <= (acc_nxt == '0);
            dbz_q    <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
          cnt <= cnt + 1'b1;
        end
        DIV_FIX: begin
          result_q <= {rem_s, quo_s};
          ovf_q    <= div_ovf;
          zero_q   <= (quo_s == '0);
          dbz_q    <= 1'b0;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: scoreboard bench for alu_seq_param
// expectations come from an integer reference model
module tb_alu_seq_param;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        zero;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_seq_param_if #(.WIDTH(W)) bus ();

  alu_seq_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t e;
    int sa, sbv, v, q, r;
    sa  = $signed(a);
    sbv = $signed(b);
    e.dbz  = 1'b0;
    e.ovf  = 1'b0;
    e.zero = 1'b0;
    e.res  = '0;
    e.lat  = 1;
    if (op[1] == 1'b0) begin
      v = op[0] ? sa - sbv : sa + sbv;
      e.res  = {{8{v[7]}}, v[7:0]};
      e.ovf  = (v > 127) || (v < -128);
      e.zero = (v[7:0] == 8'h00);
    end else if (op[0] == 1'b0) begin
      v = sa * sbv;
      e.res  = v[15:0];
      e.ovf  = (v > 127) || (v < -128);
      e.zero = (v == 0);
      e.lat  = 5;
    end else if (sbv == 0) begin
      e.res = {a, 8'hFF};
      e.ovf = 1'b1;
      e.dbz = 1'b1;
    end else if (sa == -128 && sbv == -1) begin
      e.res = 16'h0080;
      e.ovf = 1'b1;
      e.lat = 10;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e.res  = {r[7:0], q[7:0]};
      e.zero = (q == 0);
      e.lat  = 10;
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b);
    sb.push_back(model(op, a, b));
    bus.operation = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_a = 8'($urandom);
    bus.operand_b = 8'($urandom);
    bus.operation = 2'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.result, bus.ready, bus.done, bus.overflow,
         bus.zero, bus.div_by_zero} !== {16'h0, 5'b10000}) begin
      errors++;
      $display("FAIL reset_state: got res=%h rdy=%b done=%b fl=%b%b%b want 0000/1/0/000",
               bus.result, bus.ready, bus.done,
               bus.overflow, bus.zero, bus.div_by_zero);
    end
  endtask

  task automatic test_add_sub;
    logic [23:0] tbl [5] = '{
      {8'h00, 8'd100, 8'd50},
      {8'h00, 8'h80, 8'hFF},
      {8'h01, 8'h80, 8'h01},
      {8'h01, 8'h05, 8'h07},
      {8'h00, 8'h03, 8'hFD}
    };
    exp_t e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i][17:16], tbl[i][15:8], tbl[i][7:0]);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || bus.result !== e.res) begin
        errors++;
        $display("FAIL addsub[%0d]: got lat=%0d res=%h want lat=%0d res=%h",
                 i, lat, bus.result, e.lat, e.res);
      end
      checks++;
      if ({bus.overflow, bus.zero, bus.div_by_zero, bus.ready} !==
          {e.ovf, e.zero, e.dbz, 1'b1}) begin
        errors++;
        $display("FAIL addsub_flags[%0d]: got %b%b%b rdy=%b want %b%b%b rdy=1",
                 i, bus.overflow, bus.zero, bus.div_by_zero, bus.ready,
                 e.ovf, e.zero, e.dbz);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.result !== e.res) begin
        errors++;
        $display("FAIL addsub_hold[%0d]: got done=%b res=%h want done=0 res=%h",
                 i, bus.done, bus.result, e.res);
      end
    end
  endtask

  task automatic test_mul;
    logic [15:0] tbl [6] = '{
      {8'hF9, 8'h0D}, {8'd100, 8'd100}, {8'h00, 8'd77},
      {8'h80, 8'h80}, {8'h7F, 8'h80}, {8'hFF, 8'hFF}
    };
    exp_t e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(2'b10, tbl[i][15:8], tbl[i][7:0]);
      checks++;
      if (bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy[%0d]: got ready=%b want 0", i, bus.ready);
      end
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || bus.result !== e.res) begin
        errors++;
        $display("FAIL mul[%0d]: got lat=%0d res=%h want lat=%0d res=%h",
                 i, lat, bus.result, e.lat, e.res);
      end
      checks++;
      if ({bus.overflow, bus.zero, bus.div_by_zero, bus.ready} !==
          {e.ovf, e.zero, e.dbz, 1'b1}) begin
        errors++;
        $display("FAIL mul_flags[%0d]: got %b%b%b rdy=%b want %b%b%b rdy=1",
                 i, bus.overflow, bus.zero, bus.div_by_zero, bus.ready,
                 e.ovf, e.zero, e.dbz);
      end
    end
  endtask

  task automatic test_div;
    logic [15:0] tbl [8] = '{
      {8'h9C, 8'h07}, {8'h64, 8'hF9}, {8'h03, 8'h07},
      {8'h80, 8'h7F}, {8'hFF, 8'h80}, {8'h80, 8'h80},
      {8'h80, 8'hFF}, {8'h05, 8'h00}
    };
    exp_t e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(2'b11, tbl[i][15:8], tbl[i][7:0]);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || bus.result !== e.res) begin
        errors++;
        $display("FAIL div[%0d]: got lat=%0d res=%h want lat=%0d res=%h",
                 i, lat, bus.result, e.lat, e.res);
      end
      checks++;
      if ({bus.overflow, bus.zero, bus.div_by_zero, bus.ready} !==
          {e.ovf, e.zero, e.dbz, 1'b1}) begin
        errors++;
        $display("FAIL div_flags[%0d]: got %b%b%b rdy=%b want %b%b%b rdy=1",
                 i, bus.overflow, bus.zero, bus.div_by_zero, bus.ready,
                 e.ovf, e.zero, e.dbz);
      end
    end
  endtask

  task automatic test_abort;
    int seen = 0;
    issue(2'b10, 8'd100, 8'd100);
    void'(sb.pop_front());
    bus.operation = 2'b00;
    bus.operand_a = 8'd9;
    bus.operand_b = 8'd9;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.result, bus.ready, bus.done, bus.overflow,
         bus.zero, bus.div_by_zero} !== {16'h0, 5'b10000}) begin
      errors++;
      $display("FAIL abort_state: got res=%h rdy=%b done=%b fl=%b%b%b want 0000/1/0/000",
               bus.result, bus.ready, bus.done,
               bus.overflow, bus.zero, bus.div_by_zero);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
    end
    bus.operation = 2'b00;
    bus.operand_a = 8'd1;
    bus.operand_b = 8'd1;
    bus.start     = 1'b1;
    reset         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 ||
        bus.result !== 16'h0) begin
      errors++;
      $display("FAIL reset_wins: got done=%b rdy=%b res=%h want 0/1/0000",
               bus.done, bus.ready, bus.result);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    sb.push_back(model(2'b01, 8'd37, 8'd37));
    bus.operation = 2'b01;
    bus.operand_a = 8'd37;
    bus.operand_b = 8'd37;
    bus.start     = 1'b1;
    @(negedge clk);
    sb.push_back(model(2'b00, 8'd1, 8'd2));
    bus.operation = 2'b00;
    bus.operand_a = 8'd1;
    bus.operand_b = 8'd2;
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1 ||
        bus.result !== e.res || bus.zero !== e.zero) begin
      errors++;
      $display("FAIL b2b_first: got done=%b rdy=%b res=%h z=%b want 1/1/%h/%b",
               bus.done, bus.ready, bus.result, bus.zero, e.res, e.zero);
    end
    @(negedge clk);
    bus.start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== e.res ||
        bus.zero !== e.zero) begin
      errors++;
      $display("FAIL b2b_second: got done=%b res=%h z=%b want 1/%h/%b",
               bus.done, bus.result, bus.zero, e.res, e.zero);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single: got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_random;
    exp_t e;
    int lat;
    logic [1:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue(op, a, b);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || bus.result !== e.res ||
          {bus.overflow, bus.zero, bus.div_by_zero} !==
          {e.ovf, e.zero, e.dbz}) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d res=%h fl=%b%b%b want lat=%0d res=%h fl=%b%b%b",
                 i, op, a, b, lat, bus.result,
                 bus.overflow, bus.zero, bus.div_by_zero,
                 e.lat, e.res, e.ovf, e.zero, e.dbz);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.operation = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_param.md
ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 operand_a  input  WIDTH  signed two's-complement operand A (dividend for div).
REQ-005 operand_b  input  WIDTH  signed two's-complement operand B (divisor for div).
REQ-006 operation  input  2  00 add, 01 sub, 10 mul (Booth radix-4), 11 div (non-restoring).
REQ-007 start  input  1  request; SHALL be accepted only on a cycle where ready=1.
REQ-008 result  output  2*WIDTH  add/sub/mul: signed value; div: {remainder, quotient}.
REQ-009 ready  output  1  high while idle and able to accept start.
REQ-010 done  output  1  single-cycle pulse when result and flags become valid.
REQ-011 overflow  output  1  signed overflow per REQ-019..REQ-022.
REQ-012 zero  output  1  result-is-zero flag per REQ-023.
REQ-013 div_by_zero  output  1  high when the completed op was div with operand_b=0.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DIV_FIX; ready=1 exactly in IDLE.
REQ-015 On accepted start, operand_a, operand_b and operation SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-016 Latency from accepting edge to done edge: add/sub 1 cycle; mul WIDTH/2+1; div WIDTH+2; div with operand_b=0: 1 cycle.
REQ-017 result and all flags SHALL update only at the done edge and SHALL hold until the next done or reset.
REQ-018 start while ready=0 SHALL be ignored without effect on the running operation.
REQ-019 add/sub: low WIDTH bits = a+b / a-b modulo 2^WIDTH, sign-extended to 2*WIDTH; overflow = signed WIDTH-bit overflow.
REQ-020 mul: one Booth radix-4 recoding step (digit in {-2,-1,0,+1,+2}) per MUL cycle, WIDTH/2 steps; result = exact signed 2*WIDTH product; overflow=1 when product not representable in WIDTH signed bits.
REQ-021 div: one non-restoring add/subtract step per DIV cycle (WIDTH steps), DIV_FIX applies remainder correction and sign fix; quotient truncates toward zero, remainder takes sign of dividend (or zero); overflow=0 except REQ-022.
REQ-022 div corner cases: operand_b=0 -> quotient all ones, remainder=operand_a, overflow=1, div_by_zero=1; operand_a=-2^(WIDTH-1) with operand_b=-1 -> quotient=-2^(WIDTH-1), remainder=0, overflow=1.
REQ-023 zero: add/sub low WIDTH bits zero; mul full 2*WIDTH product zero; div quotient zero.
REQ-024 div_by_zero SHALL be 0 for every operation other than div by zero.
REQ-025 done SHALL be 1 for exactly one cycle per accepted start; FSM SHALL return to IDLE in that same cycle so ready=1 with done.
REQ-026 A start presented in the cycle done=1 SHALL be accepted (back-to-back operation).

Reset
REQ-027 reset=1 SHALL force IDLE, result=0, ready=1, done=0, overflow=0, zero=0, div_by_zero=0 on the next edge.
REQ-028 reset mid-operation SHALL abort it with no done pulse; reset and start in the same cycle: reset wins.

Verification (WIDTH=8)
REQ-029 add a=100, b=50 -> done 1 cycle after start, result=16'hFF96, overflow=1, zero=0.
REQ-030 mul a=-7, b=13 -> done 5 cycles after start, result=16'hFFA5, overflow=0; mul a=100, b=100 -> result=16'h2710, overflow=1.
REQ-031 div a=-100, b=7 -> done 10 cycles after start, result=16'hFEF2 (rem -2, quot -14), overflow=0.
REQ-032 div a=5, b=0 -> done 1 cycle after start, result=16'h05FF, div_by_zero=1, overflow=1; div a=-128, b=-1 -> result=16'h0080, overflow=1.
REQ-033 start mul, pulse start again 2 cycles later with new operands, then reset on cycle 3 -> second start ignored, no done, ready=1 and all outputs zero the cycle after reset.
REQ-034 sub a=b=37 with start asserted again on its done cycle as add a=1,b=2 -> first done result=0, zero=1; second done next cycle result=16'h0003.
